div_unit: RTL and testbench

- Iterative radix-2 restoring divider for RV32M: DIV, DIVU, REM, REMU.
- Sits directly downstream of the execute stage and consumes the EXE→divider operands (alu_operand_1/2) and the alu_d_ops control.
- Stalls the pipeline with a busy flag, then returns a single XLEN result for the LSU-bound ALU result mux.

---
 rtl/div_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a busy/done handshake.
// Optional result cache for repeated operands is enabled by defining DIV_RESULT_CACHE_EN.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req_i,
  input  logic [2:0]      alu_d_ops_i,
  input  logic [XLEN-1:0] alu_operand_1_i,
  input  logic [XLEN-1:0] alu_operand_2_i,
  input  logic            flush_i,
  output logic            div_busy_o,
  output logic            div_done_o,
  output logic [XLEN-1:0] div_result_o
);

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  quo_fin;
  logic [XLEN-1:0]  rem_fin;
  logic [XLEN-1:0]  result_q;
  logic             sel_quo;
  logic             sign_q;
  logic             sign_r;
  logic             special;

  logic            op_valid;
  logic            op_signed;
  logic            op_is_div;
  logic            accept;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            overflow;
  logic            cache_hit;
  logic [XLEN-1:0] hit_quo;
  logic [XLEN-1:0] hit_rem;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] res_sel;

  assign op_valid  = (alu_d_ops_i >= OP_DIV) && (alu_d_ops_i <= OP_REMU);
  assign op_signed = (alu_d_ops_i == OP_DIV) || (alu_d_ops_i == OP_REM);
  assign op_is_div = (alu_d_ops_i == OP_DIV) || (alu_d_ops_i == OP_DIVU);
  assign accept    = (state == IDLE) && div_req_i && op_valid && !flush_i;

  assign neg1 = op_signed && alu_operand_1_i[XLEN-1];
  assign neg2 = op_signed && alu_operand_2_i[XLEN-1];
  assign abs1 = neg1 ? (~alu_operand_1_i + 1'b1) : alu_operand_1_i;
  assign abs2 = neg2 ? (~alu_operand_2_i + 1'b1) : alu_operand_2_i;

  assign div_zero = (alu_operand_2_i == '0);
  assign overflow = op_signed && (alu_operand_1_i == INT_MIN) && (alu_operand_2_i == '1);

  // The shifted partial remainder can need one bit more than XLEN before the trial subtract.
  assign rem_sh = {rem, quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dvs};

  assign res_sel = sel_quo ? quo_fin : rem_fin;

`ifdef DIV_RESULT_CACHE_EN
  logic            c_vld;
  logic [XLEN-1:0] c_op1;
  logic [XLEN-1:0] c_op2;
  logic            c_sgn;
  logic [XLEN-1:0] c_quo;
  logic [XLEN-1:0] c_rem;
  logic [XLEN-1:0] raw_op1;
  logic [XLEN-1:0] raw_op2;
  logic            raw_sgn;

  assign cache_hit = c_vld && (c_op1 == alu_operand_1_i) && (c_op2 == alu_operand_2_i)
                     && (c_sgn == op_signed);
  assign hit_quo   = c_quo;
  assign hit_rem   = c_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld   <= 1'b0;
      c_op1   <= '0;
      c_op2   <= '0;
      c_sgn   <= 1'b0;
      c_quo   <= '0;
      c_rem   <= '0;
      raw_op1 <= '0;
      raw_op2 <= '0;
      raw_sgn <= 1'b0;
    end else begin
      if (accept) begin
        raw_op1 <= alu_operand_1_i;
        raw_op2 <= alu_operand_2_i;
        raw_sgn <= op_signed;
      end
      if (state == DONE && !flush_i) begin
        c_vld <= 1'b1;
        c_op1 <= raw_op1;
        c_op2 <= raw_op2;
        c_sgn <= raw_sgn;
        c_quo <= quo_fin;
        c_rem <= rem_fin;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_quo   = '0;
  assign hit_rem   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    div_busy_o = 1'b0;
    div_done_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cache_hit) begin
            state_nxt = DONE;
          end else if (div_zero || overflow) begin
            state_nxt = FIX;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        div_busy_o = 1'b1;
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(XLEN-1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        div_busy_o = 1'b1;
        state_nxt  = flush_i ? IDLE : DONE;
      end
      DONE: begin
        div_done_o = !flush_i;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The result is only committed on an unflushed done, so a flush in DONE leaves the output untouched.
  assign div_result_o = div_done_o ? res_sel : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      quo_fin  <= '0;
      rem_fin  <= '0;
      result_q <= '0;
      sel_quo  <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      special  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_quo <= op_is_div;
            sign_q  <= neg1 ^ neg2;
            sign_r  <= neg1;
            dvs     <= abs2;
            quo     <= abs1;
            rem     <= '0;
            cnt     <= '0;
            special <= 1'b0;
            if (cache_hit) begin
              quo_fin <= hit_quo;
              rem_fin <= hit_rem;
            end else if (div_zero) begin
              special <= 1'b1;
              quo_fin <= '1;
              rem_fin <= alu_operand_1_i;
            end else if (overflow) begin
              special <= 1'b1;
              quo_fin <= INT_MIN;
              rem_fin <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!special) begin
            quo_fin <= sign_q ? (~quo + 1'b1) : quo;
            rem_fin <= sign_r ? (~rem + 1'b1) : rem;
          end
        end
        DONE: begin
          if (!flush_i) begin
            result_q <= res_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: timeline/result model checked every cycle plus hand-computed results.
// Define DIV_RESULT_CACHE_EN for both files to exercise the cached path.
module tb_div_unit;

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i;
  logic [2:0]  alu_d_ops_i;
  logic [31:0] alu_operand_1_i;
  logic [31:0] alu_operand_2_i;
  logic        flush_i;
  logic        div_busy_o;
  logic        div_done_o;
  logic [31:0] div_result_o;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .div_req_i(div_req_i),
    .alu_d_ops_i(alu_d_ops_i),
    .alu_operand_1_i(alu_operand_1_i),
    .alu_operand_2_i(alu_operand_2_i),
    .flush_i(flush_i),
    .div_busy_o(div_busy_o),
    .div_done_o(div_done_o),
    .div_result_o(div_result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected timeline: busy in (m_t, m_busy_last], done pulse at m_done_cyc, else result holds m_hold.
  int          m_t = -100;
  int          m_busy_last = -100;
  int          m_done_cyc = -100;
  logic [31:0] m_res = '0;
  logic [31:0] m_hold = '0;

`ifdef DIV_RESULT_CACHE_EN
  bit          mc_vld = 1'b0;
  logic [31:0] mc_a;
  logic [31:0] mc_b;
  bit          mc_s;
`endif

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_done;
      exp_done = (cyc == m_done_cyc);
      check32("busy", {31'b0, div_busy_o}, {31'b0, (cyc > m_t) && (cyc <= m_busy_last)});
      check32("done", {31'b0, div_done_o}, {31'b0, exp_done});
      check32("result", div_result_o, exp_done ? m_res : m_hold);
    end
  end

  // mode 0: run to completion; 1: flush at T+10; 2: reset at T+5
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int mode);
    logic [31:0] r;
    int lat;
    bit sgn;
    bit spec;
    bit hit;
    r    = ref_div(op, a, b);
    sgn  = (op == OP_DIV) || (op == OP_REM);
    spec = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit  = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
    hit  = mc_vld && (a == mc_a) && (b == mc_b) && (sgn == mc_s);
`endif
    lat  = hit ? 1 : (spec ? 2 : 34);
    if (mode == 0) check32({"model_", name}, r, lit);

    alu_d_ops_i     = op;
    alu_operand_1_i = a;
    alu_operand_2_i = b;
    div_req_i       = 1'b1;
    m_t             = cyc;
    m_res           = r;
    if (mode == 0) begin
      m_busy_last = cyc + lat - 1;
      m_done_cyc  = cyc + lat;
      repeat (lat + 1) @(posedge clk);
      #2;
      div_req_i = 1'b0;
      m_hold    = r;
`ifdef DIV_RESULT_CACHE_EN
      mc_vld = 1'b1;
      mc_a   = a;
      mc_b   = b;
      mc_s   = sgn;
`endif
    end else if (mode == 1) begin
      m_busy_last = cyc + 10;
      m_done_cyc  = -100;
      repeat (10) @(posedge clk);
      #2;
      flush_i   = 1'b1;
      div_req_i = 1'b0;
      @(posedge clk);
      #2;
      flush_i = 1'b0;
    end else begin
      m_busy_last = cyc + 5;
      m_done_cyc  = -100;
      repeat (5) @(posedge clk);
      #2;
      rst       = 1'b1;
      div_req_i = 1'b0;
      @(posedge clk);
      #2;
      rst    = 1'b0;
      m_hold = '0;
`ifdef DIV_RESULT_CACHE_EN
      mc_vld = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    rst             = 1'b1;
    div_req_i       = 1'b0;
    flush_i         = 1'b0;
    alu_d_ops_i     = 3'd0;
    alu_operand_1_i = '0;
    alu_operand_2_i = '0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run_op("rem_m100_7", OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("divu_3_5",   OP_DIVU, 32'd3, 32'd5, 32'd0, 0);

    // Request while flush is high must not be accepted.
    alu_d_ops_i     = OP_DIVU;
    alu_operand_1_i = 32'd1000;
    alu_operand_2_i = 32'd3;
    div_req_i       = 1'b1;
    flush_i         = 1'b1;
    @(posedge clk);
    #2;
    div_req_i = 1'b0;
    flush_i   = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    run_op("divu_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, 1);
    run_op("divu_9_3",   OP_DIVU, 32'd9, 32'd3, 32'd3, 0);
    run_op("divu_1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd333, 0);
    run_op("divu_rst",   OP_DIVU, 32'd50, 32'd5, 32'd10, 2);
    run_op("divu_after_rst", OP_DIVU, 32'd1000, 32'd3, 32'd333, 0);
    run_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 32'd14, 0);
    run_op("rem_100_7",  OP_REM,  32'd100, 32'd7, 32'd2, 0);
    run_op("remu_100_7b", OP_REMU, 32'd100, 32'd7, 32'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
